// File: rtl/div_share_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : div_share_ctrl_if
// Brief    : Requester, result and statistics signals of the shared divider
//            controller, with master (requester/consumer) and slave
//            (controller) views.
// Revision : 1.0
// ============================================================================
interface div_share_ctrl_if #(
    parameter int N  = 8,
    parameter int CW = 16
);
    logic          a_valid;
    logic          a_ready;
    logic [N-1:0]  a_dividend;
    logic [N-1:0]  a_divisor;
    logic          b_valid;
    logic          b_ready;
    logic [N-1:0]  b_dividend;
    logic [N-1:0]  b_divisor;
    logic          res_valid;
    logic          res_ready;
    logic          res_id;
    logic [N-1:0]  res_quotient;
    logic [N-1:0]  res_remainder;
    logic          res_div0;
    logic          busy;
    logic [CW-1:0] op_count;
    logic [CW-1:0] div0_count;

    modport slave (
        input  a_valid, a_dividend, a_divisor,
        input  b_valid, b_dividend, b_divisor,
        input  res_ready,
        output a_ready, b_ready,
        output res_valid, res_id, res_quotient, res_remainder, res_div0,
        output busy, op_count, div0_count
    );

    modport master (
        output a_valid, a_dividend, a_divisor,
        output b_valid, b_dividend, b_divisor,
        output res_ready,
        input  a_ready, b_ready,
        input  res_valid, res_id, res_quotient, res_remainder, res_div0,
        input  busy, op_count, div0_count
    );
endinterface
`default_nettype wire

// File: rtl/div_share_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : divisor_nbit / div_share_ctrl
// Brief    : Combinational unsigned N-bit divider, and a two-requester
//            round-robin controller that feeds it from registered operands
//            and returns a tagged result over a valid/ready channel.
// Revision : 1.0
// ============================================================================
module divisor_nbit #(
    parameter int N = 8
) (
    input  logic [N-1:0] dividend,
    input  logic [N-1:0] divisor,
    output logic [N-1:0] quotient,
    output logic [N-1:0] remainder
);
    // Divide by zero yields zero quotient and remainder
    always_comb begin
        quotient  = '0;
        remainder = '0;
        if (divisor != '0) begin
            quotient  = dividend / divisor;
            remainder = dividend % divisor;
        end
    end
endmodule

module div_share_ctrl #(
    parameter int N  = 8,
    parameter int CW = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    div_share_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t        state;
    state_t        state_next;
    logic          rr_ptr;        // requester preferred on a tie: 0 = A, 1 = B
    logic          cur_id;
    logic [N-1:0]  op_dividend;
    logic [N-1:0]  op_divisor;
    logic [N-1:0]  div_quotient;
    logic [N-1:0]  div_remainder;
    logic          grant_a;
    logic          grant_b;
    logic          a_rdy;
    logic          b_rdy;
    logic          res_id_q;
    logic [N-1:0]  res_quotient_q;
    logic [N-1:0]  res_remainder_q;
    logic          res_div0_q;
    logic [CW-1:0] op_count_q;
    logic [CW-1:0] div0_count_q;

    // The divider only ever sees the registered operands
    divisor_nbit #(.N(N)) u_div (
        .dividend  (op_dividend),
        .divisor   (op_divisor),
        .quotient  (div_quotient),
        .remainder (div_remainder)
    );

    // Round-robin grant: a lone requester wins, a tie goes to rr_ptr
    always_comb begin
        grant_a = bus.a_valid && (!bus.b_valid || !rr_ptr);
        grant_b = bus.b_valid && (!bus.a_valid ||  rr_ptr);
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // Next-state and handshake outputs; grants are offered only in IDLE
    always_comb begin
        state_next = state;
        a_rdy      = 1'b0;
        b_rdy      = 1'b0;
        case (state)
            IDLE: begin
                a_rdy = grant_a;
                b_rdy = grant_b;
                if (grant_a || grant_b) state_next = EXEC;
            end
            EXEC: state_next = RESP;
            RESP: if (bus.res_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Operand capture and round-robin pointer update on accept
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_dividend <= '0;
            op_divisor  <= '0;
            cur_id      <= 1'b0;
            rr_ptr      <= 1'b0;
        end else if (a_rdy) begin
            op_dividend <= bus.a_dividend;
            op_divisor  <= bus.a_divisor;
            cur_id      <= 1'b0;
            rr_ptr      <= 1'b1;
        end else if (b_rdy) begin
            op_dividend <= bus.b_dividend;
            op_divisor  <= bus.b_divisor;
            cur_id      <= 1'b1;
            rr_ptr      <= 1'b0;
        end
    end

    // Result capture at the end of EXEC; held through RESP
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_id_q        <= 1'b0;
            res_quotient_q  <= '0;
            res_remainder_q <= '0;
            res_div0_q      <= 1'b0;
        end else if (state == EXEC) begin
            res_id_q        <= cur_id;
            res_quotient_q  <= div_quotient;
            res_remainder_q <= div_remainder;
            res_div0_q      <= (op_divisor == '0);
        end
    end

    // Completion statistics, counted when the consumer takes the result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_count_q   <= '0;
            div0_count_q <= '0;
        end else if (state == RESP && bus.res_ready) begin
            op_count_q <= op_count_q + CW'(1);
            if (res_div0_q) div0_count_q <= div0_count_q + CW'(1);
        end
    end

    assign bus.a_ready       = a_rdy;
    assign bus.b_ready       = b_rdy;
    assign bus.res_valid     = (state == RESP);
    assign bus.busy          = (state != IDLE);
    assign bus.res_id        = res_id_q;
    assign bus.res_quotient  = res_quotient_q;
    assign bus.res_remainder = res_remainder_q;
    assign bus.res_div0      = res_div0_q;
    assign bus.op_count      = op_count_q;
    assign bus.div0_count    = div0_count_q;
endmodule
`default_nettype wire

// File: doc/div_share_ctrl.md
# div_share_ctrl

Two-port shared divider controller. Arbitrates round-robin between requesters A and B, registers the winner's operands into one internal `divisor_nbit` instance, and captures quotient/remainder. It returns the result with a requester tag over a valid/ready channel. Sits between the ALU-side requesters and the single combinational divider, so the divider is never on a register-to-register path wider than one stage.

## Interface

Parameters:
- N, 8, operand/result width; passed to the internal `divisor_nbit`
- CW, 16, width of the statistics counters

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- a_valid  in  1  requester A has an operation
- a_ready  out  1  A's operation accepted this cycle
- a_dividend  in  N  A dividend
- a_divisor  in  N  A divisor
- b_valid  in  1  requester B has an operation
- b_ready  out  1  B's operation accepted this cycle
- b_dividend  in  N  B dividend
- b_divisor  in  N  B divisor
- res_valid  out  1  result held and valid
- res_ready  in  1  consumer takes result
- res_id  out  1  0 = result for A, 1 = result for B
- res_quotient  out  N  quotient
- res_remainder  out  N  remainder
- res_div0  out  1  operation had divisor == 0; quotient and remainder are 0
- busy  out  1  state != IDLE
- op_count  out  CW  completed results; wraps at 2^CW
- div0_count  out  CW  completed results with res_div0 = 1; wraps

## Operation

- FSM has three states: IDLE, EXEC, RESP. The state is a register, reset to IDLE.
- Grant in IDLE, combinational:
  - If only one requester is valid, that requester wins.
  - If both are valid, the requester named by rr_ptr wins.
  - If neither is valid, no grant.
- a_ready = (state == IDLE) && grant == A; b_ready is the same for B. A ready output is never high outside IDLE. Both ready outputs are never high together.
- Handshake: a transfer happens when valid && ready at a rising edge. On transfer:
  - Operands are captured into op_dividend/op_divisor.
  - The winner's id is captured into cur_id.
  - rr_ptr is set to the loser's id.
  - State goes IDLE -> EXEC.
- EXEC lasts one cycle. The divider sees only the registered operands. At the next edge:
  - quotient, remainder, cur_id and (op_divisor == 0) are captured into the res_* registers.
  - State goes EXEC -> RESP.
- RESP: res_valid = 1. res_* hold stable until res_ready = 1 at an edge. On that edge:
  - State goes RESP -> IDLE.
  - op_count increments.
  - div0_count increments if res_div0 = 1.
- Requesters may hold valid high while not granted. Operands must then stay stable; this is the requester's obligation and is not checked.
- No combinational path from res_ready to a_ready/b_ready. A new grant occurs only in IDLE.
- Arithmetic: all values are unsigned N-bit. Counters are CW-bit and wrap silently from all-ones to 0.

## Timing

- Reset values:
  - state = IDLE; rr_ptr = 0 (A); busy = 0.
  - res_valid = 0, res_id = 0, res_quotient = 0, res_remainder = 0, res_div0 = 0.
  - op_count = 0, div0_count = 0.
  - a_ready = b_ready = 0 until a valid arrives.
- Latency: accept at edge t; res_valid is high from after edge t+1.
- Minimum occupancy is 3 cycles (IDLE, EXEC, RESP) with res_ready held high. Peak throughput is 1 op / 3 cycles.
- Back-to-back: the result is consumed at edge t+2 and IDLE follows. The earliest next accept is edge t+3.
- Simultaneous A and B valid in IDLE:
  - The rr_ptr requester is granted and the other waits.
  - The waiting requester is granted at its next IDLE cycle, even if the first requester re-requests.
- Reset asserted mid-operation: all registers clear immediately and asynchronously. The in-flight operation is discarded with no result and no counter change.
- Reset release is synchronous to clk by the top level. The first accept can occur at the first edge after release.
- res_ready low in RESP: stall indefinitely. a_ready and b_ready stay 0 during the stall.

## Test plan

- Single op, N = 8: A sends 200/7 with res_ready = 1. Accepted at edge t, res_valid from after t+1, result consumed at edge t+2. Required: res_id = 0, quotient = 28, remainder = 4, res_div0 = 0, op_count = 1.
- Fairness: A and B both hold valid from reset with ops 100/9 and 50/5. Required grant order A, B, A, B, ... Results 11 r 1 (id 0) and 10 r 0 (id 1) alternate, and a_ready/b_ready are never high in the same cycle.
- Divide by zero: B sends 37/0. Required: res_id = 1, quotient = 0, remainder = 0, res_div0 = 1, div0_count = 1, op_count = 1.
- Backpressure: res_ready held low for 10 cycles after res_valid rises. Required: res_* stable, busy = 1, no ready asserted. On res_ready = 1 the op completes once and op_count increments by exactly 1.
- Reset mid-op: assert rst_n = 0 during EXEC. Required: res_valid = 0, counters = 0, state IDLE, rr_ptr = A. After release, a new A op 9/2 returns 4 r 1.
- Counter wrap with CW = 4: 17 ops. Required: op_count = 1 after the 17th completion.
